// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 W[t] generator with start delay and back-to-back blocks.
module sha256_msg_sched #(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32,
  parameter int BLK_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [BLK_W-1:0]   blocks0
);
  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;
  state_t             state;
  logic [DATA_W-1:0]  win [16];
  logic [5:0]         t;
  logic [DELAY_W-1:0] cnt;
  logic [BLK_W-1:0]   blk, nb;
  logic [BLK_W:0]     blk_n;
  logic [DATA_W-1:0]  nw, w;
  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  assign done  = state == IDLE;
  assign blk_n = {1'b0, blk} + (BLK_W+1)'(1);
  always_comb begin
    nw = s1(win[14]) + win[9] + s0(win[1]) + win[0];
    w  = (t[5:4] == 2'b00) ? in0 : nw;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out0  <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
      cnt   <= '0;
      t     <= '0;
      blk   <= '0;
      nb    <= '0;
    end else if (run) begin
      cnt   <= delay0;
      blk   <= '0;
      t     <= '0;
      nb    <= (blocks0 == '0) ? BLK_W'(1) : blocks0;
      state <= WAIT;
    end else begin
      case (state)
        WAIT: begin
          if (cnt == '0) begin
            state <= ACTIVE;
            t     <= '0;
          end else cnt <= cnt - DELAY_W'(1);
        end
        ACTIVE: begin
          out0 <= w;
          for (int i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15] <= w;
          t <= t + 6'd1;
          if (t == 6'd63) begin
            if (blk_n < {1'b0, nb}) blk <= blk_n[BLK_W-1:0];
            else state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: scoreboard bench comparing the W stream against a software schedule model.
module tb_sha256_msg_sched;
  logic        clk = 0, rst, run, done;
  logic [31:0] in0, out0, delay0, last, exp_w;
  logic [15:0] blocks0;
  logic [31:0] msg [2][16];
  logic [31:0] ew [64];
  logic [31:0] exp_q [$];
  int          vectors = 0, miscompares = 0;

  sha256_msg_sched dut (
    .clk(clk), .rst(rst), .run(run), .done(done),
    .in0(in0), .out0(out0), .delay0(delay0), .blocks0(blocks0)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout, required finish");
    $fatal(1);
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int b);
    for (int j = 0; j < 16; j++) ew[j] = msg[b][j];
    for (int j = 16; j < 64; j++)
      ew[j] = (rotr(ew[j-2], 17) ^ rotr(ew[j-2], 19) ^ (ew[j-2] >> 10)) + ew[j-7]
            + (rotr(ew[j-15], 7) ^ rotr(ew[j-15], 18) ^ (ew[j-15] >> 3)) + ew[j-16];
  endtask

  // Starts a run; abort_at >= 0 returns just before that word of the final block is applied.
  task automatic run_msg(input int d, input logic [15:0] bcfg, input int nb, input int abort_at, input bit abc);
    delay0  = d;
    blocks0 = bcfg;
    run     = 1;
    tick();
    run     = 0;
    delay0  = $urandom;
    blocks0 = 16'($urandom_range(3, 9));
    check("run_hold", out0, last);
    check("run_done", {31'b0, done}, 0);
    for (int i = 0; i <= d; i++) begin
      in0 = $urandom;
      tick();
      check("wait_hold", out0, last);
      check("wait_done", {31'b0, done}, 0);
    end
    for (int b = 0; b < nb; b++) begin
      model(b);
      for (int j = 0; j < 64; j++) begin
        if (b == nb - 1 && j == abort_at) return;
        in0 = (j < 16) ? msg[b][j] : $urandom;
        exp_q.push_back(ew[j]);
        tick();
        exp_w = exp_q.pop_front();
        check("w", out0, exp_w);
        last = exp_w;
        if (abc && b == 0 && j == 0)  check("abc_w0", out0, 32'h61626380);
        if (abc && b == 0 && j == 16) check("abc_w16", out0, 32'h61626380);
        if (abc && b == 0 && j == 17) check("abc_w17", out0, 32'h000F0000);
        if (abc && b == 0 && j == 63) check("abc_w63", out0, 32'h12B1EDEB);
        check("active_done", {31'b0, done}, {31'b0, (b == nb - 1 && j == 63)});
      end
    end
  endtask

  initial begin
    rst = 1; run = 0; in0 = 0; delay0 = 0; blocks0 = 0; last = 0;
    for (int j = 0; j < 16; j++) msg[0][j] = 0;
    msg[0][0]  = 32'h61626380;
    msg[0][15] = 32'h00000018;
    for (int j = 0; j < 16; j++) msg[1][j] = $urandom;
    #1;
    check("rst_out", out0, 0);
    check("rst_done", {31'b0, done}, 1);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      in0 = $urandom;
      tick();
      check("idle_out", out0, 0);
      check("idle_done", {31'b0, done}, 1);
    end
    run_msg(0, 1, 1, -1, 1);
    run_msg(5, 1, 1, -1, 1);
    run_msg(0, 2, 2, -1, 1);
    run_msg(0, 0, 1, -1, 1);
    run_msg(0, 1, 1, 30, 1);
    run_msg(0, 1, 1, -1, 1);
    run_msg(2, 2, 2, 63, 1);
    run_msg(0, 1, 1, -1, 1);
    for (int i = 0; i < 4; i++) begin
      in0 = $urandom;
      tick();
      check("final_hold", out0, last);
      check("final_done", {31'b0, done}, 1);
    end
    run_msg(1, 1, 1, 20, 1);
    #2 rst = 1;
    #1;
    check("async_rst_out", out0, 0);
    check("async_rst_done", {31'b0, done}, 1);
    tick();
    rst  = 0;
    last = 0;
    tick();
    check("post_rst_out", out0, 0);
    run_msg(0, 1, 1, -1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
